// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch squashes and memory-busy freezes.
// Control outputs decode the registered FSM state together with the live hazard inputs.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        idex_memread_in,
  input  logic [4:0]  idex_rd_in,
  input  logic [4:0]  ifid_rs1_in,
  input  logic [4:0]  ifid_rs2_in,
  input  logic        branch_taken_in,
  input  logic        mem_busy_in,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem,
  output logic        freeze,
  output logic [1:0]  state,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_SQUASH = 2'd2,
    ST_FREEZE = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  state_t      state_cur;
  logic        stall_inc;
  logic        flush_inc;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // x0 is hardwired zero, so a load targeting it can never create a dependency.
  function automatic logic load_use_hit(input logic       memread,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    freeze      = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    state_d     = ST_RUN;
    state_cur   = reset ? ST_RUN : state_q;

    if (mem_busy_in) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      freeze     = 1'b1;
      state_d    = ST_FREEZE;
    end else if (state_cur == ST_SQUASH) begin
      // The branch still visible in EX/MEM is the one just squashed; ignore it.
      state_d = ST_RUN;
    end else if (branch_taken_in) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      flush_inc   = 1'b1;
      state_d     = ST_SQUASH;
    end else if (state_cur != ST_STALL &&
                 load_use_hit(idex_memread_in, idex_rd_in, ifid_rs1_in, ifid_rs2_in)) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      flush_idex = 1'b1;
      stall_inc  = 1'b1;
      state_d    = ST_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      state_q <= state_d;
      if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
      if (flush_inc) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_cnt;
  assign flush_count = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        idex_memread_in;
  logic [4:0]  idex_rd_in;
  logic [4:0]  ifid_rs1_in;
  logic [4:0]  ifid_rs2_in;
  logic        branch_taken_in;
  logic        mem_busy_in;
  logic        pc_write;
  logic        ifid_write;
  logic        flush_ifid;
  logic        flush_idex;
  logic        flush_exmem;
  logic        freeze;
  logic [1:0]  state;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .idex_memread_in (idex_memread_in),
    .idex_rd_in      (idex_rd_in),
    .ifid_rs1_in     (ifid_rs1_in),
    .ifid_rs2_in     (ifid_rs2_in),
    .branch_taken_in (branch_taken_in),
    .mem_busy_in     (mem_busy_in),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .flush_exmem     (flush_exmem),
    .freeze          (freeze),
    .state           (state),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic br, input logic busy);
    @(negedge clk);
    idex_memread_in = mr;
    idex_rd_in      = rd;
    ifid_rs1_in     = rs1;
    ifid_rs2_in     = rs2;
    branch_taken_in = br;
    mem_busy_in     = busy;
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, pc_write, ifid_write, flush_ifid, flush_idex, flush_exmem, freeze},
        {26'd0, exp});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Control vector order: pc_write, ifid_write, flush_ifid, flush_idex, flush_exmem, freeze
  localparam logic [5:0] C_DEF    = 6'b110000;
  localparam logic [5:0] C_STALL  = 6'b000100;
  localparam logic [5:0] C_SQUASH = 6'b111110;
  localparam logic [5:0] C_FREEZE = 6'b000001;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick;
    tick;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_stall_cnt", stall_count, 0);
    chk("rst_flush_cnt", flush_count, 0);
    chk_ctl("rst_ctl", C_DEF);

    // Load-use on rs1
    drive(1, 5, 5, 0, 0, 0);
    chk_ctl("lu_rs1_ctl", C_STALL);
    tick;
    chk("lu_rs1_state", state, 1);
    chk("lu_rs1_cnt", stall_count, 1);
    drive(1, 5, 5, 0, 0, 0);
    chk_ctl("stall_suppress_ctl", C_DEF);
    tick;
    chk("stall_to_run", state, 0);
    chk("stall_cnt_hold", stall_count, 1);

    // Load-use on rs2
    drive(1, 7, 3, 7, 0, 0);
    chk_ctl("lu_rs2_ctl", C_STALL);
    tick;
    chk("lu_rs2_cnt", stall_count, 2);
    drive(0, 0, 0, 0, 0, 0);
    tick;
    chk("lu_rs2_back_run", state, 0);

    // Load to x0 and a non-load dependency never stall
    drive(1, 0, 0, 0, 0, 0);
    chk_ctl("x0_ctl", C_DEF);
    tick;
    chk("x0_state", state, 0);
    chk("x0_cnt", stall_count, 2);
    drive(0, 5, 5, 5, 0, 0);
    chk_ctl("nomr_ctl", C_DEF);
    tick;
    chk("nomr_cnt", stall_count, 2);

    // Branch beats load-use
    drive(1, 5, 5, 0, 1, 0);
    chk_ctl("br_lu_ctl", C_SQUASH);
    tick;
    chk("br_lu_state", state, 2);
    chk("br_lu_flush_cnt", flush_count, 1);
    chk("br_lu_stall_cnt", stall_count, 2);
    drive(1, 5, 5, 0, 1, 0);
    chk_ctl("squash_ignore_ctl", C_DEF);
    tick;
    chk("squash_to_run", state, 0);
    chk("squash_flush_hold", flush_count, 1);
    chk("squash_stall_hold", stall_count, 2);

    // Busy for three cycles with a pending branch, then release
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 1);
      chk_ctl($sformatf("busy%0d_ctl", i), C_FREEZE);
      tick;
      chk($sformatf("busy%0d_state", i), state, 3);
      chk($sformatf("busy%0d_flush", i), flush_count, 1);
    end
    drive(0, 0, 0, 0, 1, 0);
    chk_ctl("release_br_ctl", C_SQUASH);
    tick;
    chk("release_br_state", state, 2);
    chk("release_br_flush", flush_count, 2);
    drive(0, 0, 0, 0, 0, 0);
    tick;
    chk("release_back_run", state, 0);

    // Load-use on leaving FREEZE behaves as in RUN
    drive(1, 9, 9, 0, 0, 1);
    chk_ctl("busy_over_lu_ctl", C_FREEZE);
    tick;
    chk("busy_lu_state", state, 3);
    chk("busy_lu_cnt_hold", stall_count, 2);
    drive(1, 9, 0, 9, 0, 0);
    chk_ctl("freeze_lu_ctl", C_STALL);
    tick;
    chk("freeze_lu_state", state, 1);
    chk("freeze_lu_cnt", stall_count, 3);
    drive(0, 0, 0, 0, 0, 0);
    tick;

    // Flush counter wrap
    @(negedge clk);
    force dut.flush_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.flush_cnt;
    chk("preload_flush", flush_count, 32'hFFFF_FFFF);
    drive(0, 0, 0, 0, 1, 0);
    tick;
    chk("wrap_flush", flush_count, 0);
    chk("wrap_state", state, 2);
    drive(0, 0, 0, 0, 0, 0);
    tick;

    // Reset while frozen with busy still high
    drive(0, 0, 0, 0, 0, 1);
    tick;
    chk("pre_rst_freeze", state, 3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    tick;
    chk("rst_freeze_state", state, 0);
    chk("rst_freeze_stall", stall_count, 0);
    chk("rst_freeze_flush", flush_count, 0);
    @(negedge clk);
    reset = 1'b0;
    mem_busy_in = 1'b0;
    #1;
    chk_ctl("post_rst_ctl", C_DEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising clk edge only.
REQ-003 idex_memread_in  in  1  MemRead currently held at the ID/EX register output.
REQ-004 idex_rd_in  in  5  rd currently held at the ID/EX register output.
REQ-005 ifid_rs1_in, ifid_rs2_in  in  5 each  source registers of the instruction in ID.
REQ-006 branch_taken_in  in  1  branch resolved taken in MEM (Branch & zero from EX/MEM).
REQ-007 mem_busy_in  in  1  data memory not ready; whole pipeline must freeze.
REQ-008 pc_write  out  1  PC update enable.
REQ-009 ifid_write  out  1  IF/ID register load enable.
REQ-010 flush_ifid, flush_idex, flush_exmem  out  1 each  zero control bits of the named pipeline register on next edge.
REQ-011 freeze  out  1  hold ID/EX, EX/MEM, MEM/WB contents.
REQ-012 state  out  2  FSM state: 0 RUN, 1 STALL, 2 SQUASH, 3 FREEZE.
REQ-013 stall_count, flush_count  out  32 each  performance counters.

Function
REQ-014 Control outputs are combinational from registered state and current inputs; state and counters are registered.
REQ-015 Default (no event): pc_write=1, ifid_write=1, all flush=0, freeze=0.
REQ-016 Load-use hit = idex_memread_in & idex_rd_in!=0 & (idex_rd_in==ifid_rs1_in | idex_rd_in==ifid_rs2_in).
REQ-017 Priority per cycle: mem_busy_in > branch_taken_in > load-use hit > default.
REQ-018 mem_busy_in=1 (any state): pc_write=0, ifid_write=0, freeze=1, flushes=0; next state FREEZE; counters hold.
REQ-019 FREEZE: remain while mem_busy_in=1; on mem_busy_in=0 apply REQ-020..022 rules as if in RUN that same cycle and transition accordingly.
REQ-020 branch_taken_in=1 (not busy): flush_ifid=flush_idex=flush_exmem=1, pc_write=1, ifid_write=1; next state SQUASH; flush_count +1.
REQ-021 Load-use hit in RUN (not busy, no branch): pc_write=0, ifid_write=0, flush_idex=1; next state STALL; stall_count +1.
REQ-022 STALL: load-use detection suppressed (bubble in ID/EX); default outputs unless busy/branch; next state RUN.
REQ-023 SQUASH: load-use detection suppressed (wrong-path bubble); branch_taken_in ignored (EX/MEM flushed); default outputs unless busy; next state RUN.
REQ-024 Branch and load-use in same cycle: branch wins, stall_count unchanged.
REQ-025 Counters wrap 0xFFFFFFFF -> 0 silently.
REQ-026 rd=x0 never triggers a stall.

Reset
REQ-027 reset=1 at edge: state=RUN, stall_count=0, flush_count=0; overrides all inputs including mem_busy_in.
REQ-028 During reset cycle outputs follow RUN defaults with inputs applied; reset mid-STALL/SQUASH/FREEZE returns to RUN next edge.

Verification
REQ-029 Load-use: idex_memread=1, idex_rd=5, rs1=5 -> pc_write=0, ifid_write=0, flush_idex=1; next cycle state=STALL, stall_count=1; following cycle RUN.
REQ-030 x0 load: idex_memread=1, idex_rd=0, rs1=0 -> defaults, stall_count=0, state RUN.
REQ-031 Branch + load-use same cycle -> all three flushes=1, pc_write=1; state SQUASH, flush_count=1, stall_count=0.
REQ-032 mem_busy_in high 3 cycles during a branch -> freeze=1, pc_write=0, no flush for 3 cycles; on release branch flushes, flush_count=1.
REQ-033 Preload flush_count to 0xFFFFFFFF via 2^32-1 branches (or force) then branch -> flush_count=0.
REQ-034 reset asserted while in FREEZE with mem_busy_in=1 -> next edge state=RUN, counters=0.
